// File: rtl/countdown_step_controller.sv
// Run-for-N-core-cycles countdown: arms out of manual mode, counts core_clock rising
// edges, then pulses countdown_timed_up for HOLD_CYCLES cycles to force manual mode.
module countdown_step_controller #(
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned DEFAULT_STEPS = 1000,
  parameter int unsigned HOLD_CYCLES   = 4
) (
  input  logic                   clock_100mhz,
  input  logic                   reset,
  input  logic                   core_clock,
  input  logic                   countdown_reset,
  input  logic                   countdown_enable,
  input  logic                   load_strobe,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic                   countdown_timed_up,
  output logic [COUNT_WIDTH-1:0] remaining_steps,
  output logic                   busy
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] RUNNING     = 2'd1;
  localparam logic [1:0] EXPIRED     = 2'd2;
  localparam logic [1:0] WAIT_MANUAL = 2'd3;

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST   = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]      HOLD_ONE    = HOLD_W'(1);
  localparam logic [COUNT_WIDTH-1:0] STEPS_RESET = COUNT_WIDTH'(DEFAULT_STEPS);
  localparam logic [COUNT_WIDTH-1:0] STEP_ONE    = COUNT_WIDTH'(1);

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] step_target;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   core_clock_q;
  logic                   core_rise;

  // core_clock is already a clock_100mhz-domain register, so a single delay suffices
  assign core_rise          = core_clock & ~core_clock_q;
  assign busy               = (state == RUNNING);
  assign countdown_timed_up = (state == EXPIRED);

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state           <= IDLE;
      step_target     <= STEPS_RESET;
      remaining_steps <= STEPS_RESET;
      hold_cnt        <= '0;
      core_clock_q    <= 1'b0;
    end else begin
      core_clock_q <= core_clock;
      if (load_strobe) begin
        step_target <= load_value;
      end

      case (state)
        IDLE: begin
          remaining_steps <= step_target;
          if (!countdown_reset && countdown_enable && (step_target != '0)) begin
            state <= RUNNING;
          end
        end
        RUNNING: begin
          // Manual mode wins over a coincident final edge: no pulse in that case
          if (countdown_reset || !countdown_enable) begin
            state <= IDLE;
          end else if (core_rise) begin
            if (remaining_steps > STEP_ONE) begin
              remaining_steps <= remaining_steps - STEP_ONE;
            end else if (remaining_steps == STEP_ONE) begin
              remaining_steps <= '0;
              hold_cnt        <= HOLD_ONE;
              state           <= EXPIRED;
            end
          end
        end
        EXPIRED: begin
          // Deliberately ignores countdown_reset so the pulse is never truncated
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            state    <= WAIT_MANUAL;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        WAIT_MANUAL: begin
          if (countdown_reset) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_step_controller.sv
// Directed bench for countdown_step_controller with a cycle-level behavioural model.
module tb_countdown_step_controller;

  localparam int unsigned CW   = 32;
  localparam int unsigned DEF  = 1000;
  localparam int unsigned HOLD = 4;

  logic          clock_100mhz = 1'b0;
  logic          reset;
  logic          core_clock;
  logic          countdown_reset;
  logic          countdown_enable;
  logic          load_strobe;
  logic [CW-1:0] load_value;
  logic          countdown_timed_up;
  logic [CW-1:0] remaining_steps;
  logic          busy;

  countdown_step_controller #(
    .COUNT_WIDTH(CW), .DEFAULT_STEPS(DEF), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock_100mhz      (clock_100mhz),
    .reset             (reset),
    .core_clock        (core_clock),
    .countdown_reset   (countdown_reset),
    .countdown_enable  (countdown_enable),
    .load_strobe       (load_strobe),
    .load_value        (load_value),
    .countdown_timed_up(countdown_timed_up),
    .remaining_steps   (remaining_steps),
    .busy              (busy)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: armed / pulse-countdown / latched-until-manual, plus a target and a counter
  logic [CW-1:0] m_target, m_rem, m_next_target;
  logic          m_armed, m_waiting, m_prev, m_rise;
  int            m_pulse;
  bit            chk_en = 1'b0;

  always @(posedge clock_100mhz) begin
    if (reset) begin
      m_target = DEF; m_rem = DEF; m_armed = 0; m_waiting = 0; m_prev = 0; m_pulse = 0;
    end else begin
      m_rise = core_clock && !m_prev;
      m_prev = core_clock;
      m_next_target = load_strobe ? load_value : m_target;
      if (m_pulse > 0) begin
        m_pulse = m_pulse - 1;
        if (m_pulse == 0) m_waiting = 1;
      end else if (m_waiting) begin
        if (countdown_reset) m_waiting = 0;
      end else if (m_armed) begin
        if (countdown_reset || !countdown_enable) m_armed = 0;
        else if (m_rise) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_armed = 0;
            m_pulse = HOLD;
          end
        end
      end else begin
        m_rem = m_target;
        if (!countdown_reset && countdown_enable && m_target != 0) m_armed = 1;
      end
      m_target = m_next_target;
    end
  end

  always @(negedge clock_100mhz) begin
    if (chk_en) begin
      check("model_timed_up", 64'(countdown_timed_up), 64'(m_pulse > 0));
      check("model_busy", 64'(busy), 64'(m_armed));
      check("model_remaining", 64'(remaining_steps), 64'(m_rem));
    end
  end

  int tu_seen = 0;
  int busy_seen = 0;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock_100mhz);
      tu_seen   += int'(countdown_timed_up);
      busy_seen += int'(busy);
    end
  endtask

  task automatic core_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      core_clock = 1'b1;
      tick(2);
      core_clock = 1'b0;
      tick(2);
    end
  endtask

  task automatic load(input logic [CW-1:0] v);
    load_value  = v;
    load_strobe = 1'b1;
    tick(1);
    load_strobe = 1'b0;
    tick(1);
  endtask

  int tu0, b0, cnt;

  initial begin
    reset = 1'b1; core_clock = 1'b0; countdown_reset = 1'b1; countdown_enable = 1'b1;
    load_strobe = 1'b0; load_value = '0;
    tick(2);
    chk_en = 1'b1;
    reset = 1'b0;
    tick(1);
    check("reset_remaining", 64'(remaining_steps), 64'd1000);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_timed_up", 64'(countdown_timed_up), 64'd0);

    // Arm with the default target and count three core edges
    countdown_reset = 1'b0;
    tick(1);
    check("arm_busy", 64'(busy), 64'd1);
    core_pulse(3);
    check("run3_remaining", 64'(remaining_steps), 64'd997);
    check("run3_timed_up", 64'(countdown_timed_up), 64'd0);

    // Load 5 and run to expiry
    countdown_reset = 1'b1;
    tick(1);
    load(5);
    tick(1);
    check("load5_remaining", 64'(remaining_steps), 64'd5);
    countdown_reset = 1'b0;
    tick(1);
    core_pulse(4);
    check("run4_remaining", 64'(remaining_steps), 64'd1);
    core_clock = 1'b1;
    tick(1);
    check("expiry_timed_up", 64'(countdown_timed_up), 64'd1);
    check("expiry_remaining", 64'(remaining_steps), 64'd0);
    check("expiry_busy", 64'(busy), 64'd0);
    cnt = 1;
    for (int i = 0; i < 29; i++) begin
      core_clock = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
      cnt += int'(countdown_timed_up);
    end
    check("pulse_width", 64'(cnt), 64'd4);
    check("no_second_pulse", 64'(countdown_timed_up), 64'd0);
    core_clock = 1'b0;

    // Manual mode arrives together with the final core edge
    countdown_reset = 1'b1;
    tick(2);
    load(3);
    tick(1);
    countdown_reset = 1'b0;
    tick(1);
    core_pulse(2);
    check("abort_pre_remaining", 64'(remaining_steps), 64'd1);
    tu0 = tu_seen;
    core_clock = 1'b1;
    countdown_reset = 1'b1;
    tick(1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_timed_up", 64'(countdown_timed_up), 64'd0);
    tick(1);
    check("abort_reload", 64'(remaining_steps), 64'd3);
    core_clock = 1'b0;
    tick(8);
    check("abort_no_pulse", 64'(tu_seen - tu0), 64'd0);

    // Zero target never arms
    load(0);
    countdown_reset = 1'b0;
    tu0 = tu_seen; b0 = busy_seen;
    core_pulse(50);
    check("zero_no_pulse", 64'(tu_seen - tu0), 64'd0);
    check("zero_never_busy", 64'(busy_seen - b0), 64'd0);

    // Disabled countdown never arms
    countdown_reset = 1'b1;
    load(1000);
    countdown_enable = 1'b0;
    countdown_reset = 1'b0;
    tu0 = tu_seen; b0 = busy_seen;
    core_pulse(50);
    check("dis_no_pulse", 64'(tu_seen - tu0), 64'd0);
    check("dis_never_busy", 64'(busy_seen - b0), 64'd0);
    check("dis_remaining", 64'(remaining_steps), 64'd1000);

    // Load mid-run does not disturb the running count
    countdown_enable = 1'b1;
    countdown_reset = 1'b1;
    load(402);
    countdown_reset = 1'b0;
    tick(1);
    core_pulse(2);
    check("mid_remaining", 64'(remaining_steps), 64'd400);
    load_value = 7; load_strobe = 1'b1;
    tick(1);
    load_strobe = 1'b0;
    check("mid_load_keep", 64'(remaining_steps), 64'd400);
    check("mid_load_busy", 64'(busy), 64'd1);
    core_pulse(1);
    check("mid_continue", 64'(remaining_steps), 64'd399);
    countdown_reset = 1'b1;
    tick(2);
    countdown_reset = 1'b0;
    tick(1);
    check("reenter_remaining", 64'(remaining_steps), 64'd7);
    check("reenter_busy", 64'(busy), 64'd1);

    // Reset in the second hold cycle
    core_pulse(6);
    core_clock = 1'b1;
    tick(1);
    check("hold1_timed_up", 64'(countdown_timed_up), 64'd1);
    tick(1);
    check("hold2_timed_up", 64'(countdown_timed_up), 64'd1);
    reset = 1'b1;
    tick(1);
    check("rst_timed_up", 64'(countdown_timed_up), 64'd0);
    check("rst_remaining", 64'(remaining_steps), 64'd1000);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    core_clock = 1'b0;
    tick(2);

    // All-ones target runs as a full count
    countdown_reset = 1'b1;
    tick(1);
    load(32'hFFFF_FFFF);
    tick(1);
    check("max_remaining", 64'(remaining_steps), 64'hFFFF_FFFF);
    countdown_reset = 1'b0;
    tick(1);
    check("max_busy", 64'(busy), 64'd1);
    core_pulse(1);
    check("max_decrement", 64'(remaining_steps), 64'hFFFF_FFFE);
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
